qed_instruction_queue: RTL and testbench

//  Upstream neighbour of the QED instruction modifier. Records original instructions issued from fetch.

---
 rtl/qed_instruction_queue.sv | 114 +++++++++++
 tb/tb_qed_instruction_queue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/qed_instruction_queue.sv
// Records fetch-stage originals, then replays them in order for the QED duplicate stream.
// Optional build macro: QIC_FILTER_NOP_EN (NOPs bypass the queue while recording originals).
module qed_instruction_queue #(
  parameter int          DEPTH  = 16,
  parameter int          ADDR_W = 4,
  parameter logic [31:0] NOP    = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              exec_dup,
  input  logic [31:0]       ifu_qed_instruction,
  output logic [31:0]       qic_qimux_instruction,
  output logic              qic_dup_valid,
  output logic [ADDR_W:0]   num_orig_insts,
  output logic [ADDR_W:0]   num_dup_insts,
  output logic              qed_ready
);

  // state | meaning
  // ORIG  | recording originals from fetch
  // DUP   | replaying queued originals
  // DONE  | all originals replayed; sticky until reset
  localparam logic [1:0] ST_ORIG = 2'd0;
  localparam logic [1:0] ST_DUP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [31:0]       mem [DEPTH];
  logic              is_filtered;
  logic              full;
  logic              push;

`ifdef QIC_FILTER_NOP_EN
  assign is_filtered = (ifu_qed_instruction == NOP);
`else
  assign is_filtered = 1'b0;
`endif

  assign full = (count == FULL_CNT);
  assign push = ena && (state == ST_ORIG) && !exec_dup && !full && !is_filtered;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ifu_qed_instruction;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= ST_ORIG;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      count                 <= '0;
      num_orig_insts        <= '0;
      num_dup_insts         <= '0;
      qic_qimux_instruction <= NOP;
      qic_dup_valid         <= 1'b0;
      qed_ready             <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_ORIG: begin
          qic_dup_valid <= 1'b0;
          if (exec_dup) begin
            // the fetch word arriving with exec_dup is dropped to keep orig/dup pairing
            qic_qimux_instruction <= NOP;
            if (count == '0) begin
              state     <= ST_DONE;
              qed_ready <= 1'b1;
            end else begin
              state <= ST_DUP;
            end
          end else if (push) begin
            qic_qimux_instruction <= ifu_qed_instruction;
            wr_ptr                <= wr_ptr + ADDR_W'(1);
            count                 <= count + ONE_CNT;
            num_orig_insts        <= num_orig_insts + ONE_CNT;
          end else if (is_filtered) begin
            qic_qimux_instruction <= ifu_qed_instruction;
          end else begin
            qic_qimux_instruction <= NOP;
          end
        end
        ST_DUP: begin
          if (count != '0) begin
            qic_qimux_instruction <= mem[rd_ptr];
            qic_dup_valid         <= 1'b1;
            rd_ptr                <= rd_ptr + ADDR_W'(1);
            count                 <= count - ONE_CNT;
            num_dup_insts         <= num_dup_insts + ONE_CNT;
            if (count == ONE_CNT) state <= ST_DONE;
          end else begin
            qic_qimux_instruction <= NOP;
            qic_dup_valid         <= 1'b0;
            state                 <= ST_DONE;
            qed_ready             <= 1'b1;
          end
        end
        ST_DONE: begin
          // qed_ready trails the last replay by one cycle
          qic_qimux_instruction <= NOP;
          qic_dup_valid         <= 1'b0;
          qed_ready             <= 1'b1;
        end
        default: state <= ST_ORIG;
      endcase
    end
  end

endmodule

// File: tb/tb_qed_instruction_queue.sv
// Directed bench for qed_instruction_queue: record, replay, full queue, stalls, resets.
module tb_qed_instruction_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        exec_dup;
  logic [31:0] ifu_qed_instruction;
  logic [31:0] qic_qimux_instruction;
  logic        qic_dup_valid;
  logic [4:0]  num_orig_insts;
  logic [4:0]  num_dup_insts;
  logic        qed_ready;

  int n_cmp = 0;
  int n_err = 0;

  qed_instruction_queue dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ena                   (ena),
    .exec_dup              (exec_dup),
    .ifu_qed_instruction   (ifu_qed_instruction),
    .qic_qimux_instruction (qic_qimux_instruction),
    .qic_dup_valid         (qic_dup_valid),
    .num_orig_insts        (num_orig_insts),
    .num_dup_insts         (num_dup_insts),
    .qed_ready             (qed_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic d, input logic [31:0] ins);
    rst_n = 1'b1; ena = e; exec_dup = d; ifu_qed_instruction = ins;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; exec_dup = 1'b0; ifu_qed_instruction = 32'hdead_beef;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] ins, input logic v,
                           input int no, input int nd, input logic rdy);
    check({tag, ".instr"}, qic_qimux_instruction, ins);
    check({tag, ".valid"}, 32'(qic_dup_valid), 32'(v));
    check({tag, ".norig"}, 32'(num_orig_insts), 32'(no));
    check({tag, ".ndup"},  32'(num_dup_insts), 32'(nd));
    check({tag, ".ready"}, 32'(qed_ready), 32'(rdy));
  endtask

  logic [31:0] vec3 [3] = '{32'h0020_8033, 32'h0031_0093, 32'h0000_2183};

  initial begin
    rst_n = 1'b0; ena = 1'b1; exec_dup = 1'b0; ifu_qed_instruction = '0;

    // 1: reset with ena high
    do_reset();
    check_out("rst", NOP, 1'b0, 0, 0, 1'b0);

    // 2: three originals then replay
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, vec3[i]);
      check_out($sformatf("orig%0d", i), vec3[i], 1'b0, i + 1, 0, 1'b0);
    end
    drive(1'b0, 1'b0, 32'h1111_1111);
    check_out("orig_hold", vec3[2], 1'b0, 3, 0, 1'b0);
    drive(1'b1, 1'b1, 32'h2222_2222);
    check_out("switch", NOP, 1'b0, 3, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h3333_3333);
      check_out($sformatf("dup%0d", i), vec3[i], 1'b1, 3, i + 1, 1'b0);
    end
    drive(1'b1, 1'b0, 32'h4444_4444);
    check_out("done", NOP, 1'b0, 3, 3, 1'b1);
    drive(1'b1, 1'b1, 32'h5555_5555);
    check_out("done_sticky", NOP, 1'b0, 3, 3, 1'b1);

    // 3: fill to 16, 17th stalls with NOP, then full replay
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'h0000_1000 + 32'(i));
      check($sformatf("fill%0d", i), qic_qimux_instruction, 32'h0000_1000 + 32'(i));
    end
    check("fill.norig", 32'(num_orig_insts), 32'd16);
    drive(1'b1, 1'b0, 32'h0000_2000);
    check_out("full17", NOP, 1'b0, 16, 0, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_2001);
    check_out("full_switch", NOP, 1'b0, 16, 0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'h0000_3000);
      check_out($sformatf("rep%0d", i), 32'h0000_1000 + 32'(i), 1'b1, 16, i + 1, 1'b0);
    end
    drive(1'b1, 1'b0, 32'h0);
    check_out("full_done", NOP, 1'b0, 16, 16, 1'b1);

    // 4: stall mid-replay
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'h0000_5000 + 32'(i));
    drive(1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    check_out("st_rep0", 32'h0000_5000, 1'b1, 4, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      check_out($sformatf("stall%0d", i), 32'h0000_5000, 1'b1, 4, 1, 1'b0);
    end
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      check_out($sformatf("st_rep%0d", i), 32'h0000_5000 + 32'(i), 1'b1, 4, i + 1, 1'b0);
    end

    // 5a: exec_dup with empty queue goes straight to DONE
    do_reset();
    drive(1'b1, 1'b1, 32'h0000_6000);
    check_out("empty_dup", NOP, 1'b0, 0, 0, 1'b1);

    // 5b: reset in the middle of replay
    do_reset();
    drive(1'b1, 1'b0, 32'h0000_7000);
    drive(1'b1, 1'b0, 32'h0000_7001);
    drive(1'b1, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    check_out("mid_rep", 32'h0000_7000, 1'b1, 2, 1, 1'b0);
    rst_n = 1'b0; ena = 1'b1;
    step();
    check_out("mid_rst", NOP, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 32'h0000_7777);
    check_out("after_rst", 32'h0000_7777, 1'b0, 1, 0, 1'b0);

    // 6: NOP filtering option
    do_reset();
    drive(1'b1, 1'b0, NOP);
    check("flt0.instr", qic_qimux_instruction, NOP);
    drive(1'b1, 1'b0, 32'h0020_8033);
    drive(1'b1, 1'b0, NOP);
    check("flt2.instr", qic_qimux_instruction, NOP);
`ifdef QIC_FILTER_NOP_EN
    check("flt.norig", 32'(num_orig_insts), 32'd1);
`else
    check("flt.norig", 32'(num_orig_insts), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
